// File: rtl/dram_bus_bridge_pkg.sv
// Shared constants and helpers for the DRAM bus bridge and its response FIFO.
package dram_bus_bridge_pkg;

    localparam int DATA_W   = 32;
    localparam int MASK_W   = 4;
    localparam int DRAM_LAT = 1;

    // Smallest r such that (1 << r) >= value; used for pointer widths.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dram_resp_fifo.sv
// In-order read-response buffer; push and pop may coincide even when full.
module dram_resp_fifo
    import dram_bus_bridge_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_din,
    input  logic              i_pop,
    output logic [CNT_W-1:0]  o_count,
    output logic [DATA_W-1:0] o_head,
    output logic              o_empty
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_full;
    logic              w_pop;
    logic              w_push;

    assign o_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = i_pop && !o_empty;
    // A full FIFO may only accept data when the head leaves on the same edge.
    assign w_push  = i_push && (!w_full || w_pop);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
        !(i_push && w_full && !w_pop));

endmodule

// File: rtl/dram_bus_bridge.sv
// Core REQ/ACK bus to single-cycle DRAM port, with credit-limited reads and
// an in-order response buffer in front of the consumer.
module dram_bus_bridge
    import dram_bus_bridge_pkg::*;
#(
    parameter int RESP_DEPTH = 2,
    parameter int ADDR_W     = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] BUS_ADDR,
    input  logic              BUS_REQ,
    input  logic              BUS_WE,
    input  logic [MASK_W-1:0] BUS_MASK,
    input  logic [DATA_W-1:0] BUS_WDATA,
    output logic              BUS_ACK,
    output logic [DATA_W-1:0] BUS_RDATA,
    output logic              BUS_RVALID,
    input  logic              BUS_RREADY,
    output logic [ADDR_W-1:0] DRAM_ADDR,
    output logic              DRAM_CS,
    output logic              DRAM_WR,
    output logic [MASK_W-1:0] DRAM_MASK,
    output logic [DATA_W-1:0] DRAM_DIN,
    input  logic [DATA_W-1:0] DRAM_DOUT
);

    localparam int CNT_W = clog2(RESP_DEPTH) + 1;

    logic              r_inflight;
    logic [CNT_W-1:0]  w_fifo_count;
    logic [CNT_W:0]    w_outstanding;
    logic              w_read_ok;
    logic              w_fifo_empty;
    logic              w_pop;

    // Handshakes: a request transfers when BUS_REQ && BUS_ACK; a response
    // transfers when BUS_RVALID && BUS_RREADY. An unacknowledged request is
    // held unchanged by the master; BUS_RDATA is stable while not taken.

    // Credits: buffered responses plus the read on the DRAM wire.
    assign w_outstanding = {1'b0, w_fifo_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_read_ok     = (w_outstanding < (CNT_W + 1)'(RESP_DEPTH));
    assign BUS_ACK       = !RST && BUS_REQ && (BUS_WE || w_read_ok);

    assign DRAM_CS   = BUS_ACK;
    assign DRAM_WR   = BUS_WE;
    assign DRAM_ADDR = BUS_ADDR;
    assign DRAM_MASK = BUS_MASK;
    assign DRAM_DIN  = BUS_WDATA;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= BUS_ACK && !BUS_WE;
        end
    end

    assign BUS_RVALID = !w_fifo_empty;
    assign w_pop      = BUS_RVALID && BUS_RREADY;

    dram_resp_fifo #(
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .i_push  (r_inflight),
        .i_din   (DRAM_DOUT),
        .i_pop   (w_pop),
        .o_count (w_fifo_count),
        .o_head  (BUS_RDATA),
        .o_empty (w_fifo_empty)
    );

endmodule
